// File: rtl/alu_wide_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_wide_sequencer
// Brief   : Runs 32-bit two-operand ops as two 16-bit ALU micro-ops
//           (low word, then high word with carry/borrow chaining).
// Revision: 1.0 - initial release
// ============================================================================
module alu_wide_sequencer #(
    parameter int WORD_W = 16
) (
    input  logic                  clk_pi,
    input  logic                  reset_pi,
    input  logic                  start_pi,
    input  logic [2:0]            func_pi,
    input  logic [2*WORD_W-1:0]   a_pi,
    input  logic [2*WORD_W-1:0]   b_pi,
    input  logic [WORD_W-1:0]     alu_result_pi,
    input  logic                  alu_carry_pi,
    input  logic                  alu_borrow_pi,
    output logic                  arith_2op_po,
    output logic [2:0]            alu_func_po,
    output logic [WORD_W-1:0]     reg1_data_po,
    output logic [WORD_W-1:0]     reg2_data_po,
    output logic                  carry_in_po,
    output logic                  borrow_in_po,
    output logic [2*WORD_W-1:0]   result_po,
    output logic                  carry_po,
    output logic                  borrow_po,
    output logic                  busy_po,
    output logic                  done_po
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [2*WORD_W-1:0]   r_a;
    logic [2*WORD_W-1:0]   r_b;
    logic [2:0]            r_func;
    logic [2*WORD_W-1:0]   r_result;
    logic                  r_carry;
    logic                  r_borrow;
    logic                  r_chain_c;
    logic                  r_chain_b;

    // func[2]=0 is arithmetic; func[1] selects add (0) or sub (1)
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_func    <= '0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_borrow  <= 1'b0;
            r_chain_c <= 1'b0;
            r_chain_b <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start_pi) begin
                        r_a    <= a_pi;
                        r_b    <= b_pi;
                        r_func <= func_pi;
                    end
                end
                S_LOW: begin
                    r_result[WORD_W-1:0] <= alu_result_pi;
                    r_chain_c            <= alu_carry_pi;
                    r_chain_b            <= alu_borrow_pi;
                end
                S_HIGH: begin
                    r_result[2*WORD_W-1:WORD_W] <= alu_result_pi;
                    if (!r_func[2]) begin
                        if (!r_func[1]) r_carry  <= alu_carry_pi;
                        else            r_borrow <= alu_borrow_pi;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next       = r_state;
        arith_2op_po = 1'b0;
        alu_func_po  = 3'b000;
        reg1_data_po = '0;
        reg2_data_po = '0;
        carry_in_po  = 1'b0;
        borrow_in_po = 1'b0;
        busy_po      = 1'b1;
        done_po      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_po = 1'b0;
                if (start_pi) w_next = S_LOW;
            end
            S_LOW: begin
                arith_2op_po = 1'b1;
                alu_func_po  = r_func;
                reg1_data_po = r_a[WORD_W-1:0];
                reg2_data_po = r_b[WORD_W-1:0];
                carry_in_po  = r_carry;
                borrow_in_po = r_borrow;
                w_next       = S_HIGH;
            end
            S_HIGH: begin
                arith_2op_po = 1'b1;
                // high word always chains: ADD->ADDC, SUB->SUBB
                alu_func_po  = r_func[2] ? r_func : {r_func[2:1], 1'b1};
                reg1_data_po = r_a[2*WORD_W-1:WORD_W];
                reg2_data_po = r_b[2*WORD_W-1:WORD_W];
                carry_in_po  = r_chain_c;
                borrow_in_po = r_chain_b;
                w_next       = S_DONE;
            end
            S_DONE: begin
                done_po = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign result_po = r_result;
    assign carry_po  = r_carry;
    assign borrow_po = r_borrow;

endmodule
`default_nettype wire
